// File: rtl/counter_mod_prog.sv
// Programmable up/down mod-N counter with wrap, saturate and one-shot ends.
// tc is a combinational terminal strobe meant to cascade into the next en.
module counter_mod_prog #(
  parameter int WIDTH   = 8,
  parameter int RST_MOD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] RST_MODV = WIDTH'(RST_MOD);

  state_t           state, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_reg, mod_d;
  logic [WIDTH-1:0] top, tv, load_clamp;
  logic             done_q, done_d;
  logic             at_tv, step;

  // mod_reg of zero selects the full 2^WIDTH range
  assign top = (mod_reg == '0) ? '1 : mod_reg - 1'b1;
  assign tv = up_dn ? top : '0;
  assign at_tv = (count_q == tv);
  assign load_clamp = (load_val > top) ? top : load_val;
  assign step = en & (state == RUN);

  assign tc = rst_n & step & at_tv
            & ~mod_wr & ~clr & ~load;

  assign count = count_q;
  assign done = done_q;

  always_comb begin
    count_d = count_q;
    mod_d = mod_reg;
    state_d = state;
    done_d = done_q;
    if (mod_wr) begin
      mod_d = mod_val;
      count_d = '0;
      state_d = RUN;
      done_d = 1'b0;
    end else if (clr) begin
      count_d = '0;
      state_d = RUN;
      done_d = 1'b0;
    end else if (load) begin
      count_d = load_clamp;
      state_d = RUN;
      done_d = 1'b0;
    end else if (step) begin
      if (!at_tv) begin
        count_d = up_dn ? count_q + 1'b1
                        : count_q - 1'b1;
      end else begin
        unique case (mode)
          2'b01: count_d = count_q;
          2'b10: begin
            state_d = HALT;
            done_d = 1'b1;
          end
          default: count_d = up_dn ? '0 : top;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mod_reg <= RST_MODV;
      state <= RUN;
      done_q <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_reg <= mod_d;
      state <= state_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_mod_prog.sv
// Bench for counter_mod_prog: directed scenarios plus random traffic
// checked against an arithmetic reference model.
module tb_counter_mod_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_dn, mod_wr, load, clr;
  logic [1:0] mode;
  logic [7:0] mod_val, load_val;
  logic [7:0] count;
  logic       tc, done;

  int tests = 0;
  int fails = 0;

  int m_count, m_mod;
  bit m_halt, m_done;

  always #5 clk = ~clk;

  counter_mod_prog #(.WIDTH(8), .RST_MOD(100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .mode(mode), .mod_wr(mod_wr), .mod_val(mod_val),
    .load(load), .load_val(load_val), .clr(clr),
    .count(count), .tc(tc), .done(done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_top();
    return ((m_mod == 0) ? 256 : m_mod) - 1;
  endfunction

  function automatic int m_tv();
    return up_dn ? m_top() : 0;
  endfunction

  task automatic m_reset();
    m_count = 0;
    m_mod = 100;
    m_halt = 0;
    m_done = 0;
  endtask

  function automatic bit m_tc();
    return en && !m_halt && (m_count == m_tv())
        && !mod_wr && !clr && !load;
  endfunction

  task automatic m_step();
    if (mod_wr) begin
      m_mod = mod_val;
      m_count = 0; m_halt = 0; m_done = 0;
    end else if (clr) begin
      m_count = 0; m_halt = 0; m_done = 0;
    end else if (load) begin
      m_count = (load_val > m_top()) ? m_top() : load_val;
      m_halt = 0; m_done = 0;
    end else if (en && !m_halt) begin
      if (m_count != m_tv())
        m_count = up_dn ? m_count + 1 : m_count - 1;
      else if (mode == 2'b01)
        m_count = m_count;
      else if (mode == 2'b10) begin
        m_halt = 1; m_done = 1;
      end else
        m_count = up_dn ? 0 : m_top();
    end
  endtask

  // Called just after a posedge; checks tc mid-cycle, then the edge result.
  task automatic tick(input string tag);
    bit exp_tc;
    exp_tc = m_tc();
    @(negedge clk);
    chk({tag, ".tc"}, tc, exp_tc);
    @(posedge clk);
    m_step();
    #1;
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".done"}, done, m_done);
  endtask

  task automatic idle();
    en = 0; up_dn = 1; mode = 0; mod_wr = 0;
    mod_val = 0; load = 0; load_val = 0; clr = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", count, 0);
    chk("rst.tc", tc, 0);
    chk("rst.done", done, 0);
    rst_n = 1;

    en = 1; up_dn = 1; mode = 2'b00;
    repeat (105) tick("wrap100");

    mod_wr = 1; mod_val = 5; up_dn = 0;
    tick("mw5");
    mod_wr = 0;
    repeat (7) tick("down5");

    mod_wr = 1; mod_val = 10; up_dn = 1; mode = 2'b01;
    tick("mw10");
    mod_wr = 0;
    repeat (12) tick("sat10");
    chk("sat10.hold", count, 9);

    mod_wr = 1; mod_val = 4; mode = 2'b10;
    tick("mw4");
    mod_wr = 0;
    repeat (6) tick("oneshot");
    chk("oneshot.done", done, 1);
    mode = 2'b00;
    repeat (2) tick("halt_wrap");
    load = 1; load_val = 2;
    tick("reload");
    chk("reload.count", count, 2);
    load = 0;
    repeat (3) tick("rerun");

    mod_wr = 1; mod_val = 0; mode = 2'b00;
    tick("mw0");
    mod_wr = 0;
    repeat (260) tick("full256");

    mod_wr = 1; mod_val = 50;
    tick("mw50");
    mod_wr = 0; load = 1; load_val = 200;
    tick("clamp");
    chk("clamp.count", count, 49);
    load = 0;
    tick("clamp_wrap");

    load = 1; load_val = 3; clr = 1;
    mod_wr = 1; mod_val = 7;
    tick("prio");
    chk("prio.count", count, 0);
    mod_wr = 0;
    tick("clr_over_load");
    clr = 0;
    tick("load_only");
    load = 0;
    repeat (4) tick("mod7");

    #2 rst_n = 0; up_dn = 0;
    #1;
    chk("async.count", count, 0);
    chk("async.tc", tc, 0);
    chk("async.done", done, 0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1; up_dn = 1;
    repeat (102) tick("post_rst");

    for (int i = 0; i < 600; i++) begin
      mod_wr = ($urandom_range(31) == 0);
      mod_val = ($urandom_range(3) == 0) ?
                8'($urandom_range(255)) :
                8'($urandom_range(12));
      clr = ($urandom_range(15) == 0);
      load = ($urandom_range(15) == 0);
      load_val = 8'($urandom_range(255));
      en = ($urandom_range(3) != 0);
      up_dn = 1'($urandom_range(1));
      mode = 2'($urandom_range(3));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
